// File: rtl/uart_rx_parity.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit.
// Recovers frames from an asynchronous line and reports data plus parity/framing status.
`timescale 1ns/1ps

module uart_rx_parity #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_line,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            rx_meta;
  logic            rx_s;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      sh;
  logic            par_bit;
  logic            bit_end;
  logic            shift_en;
  logic            par_en;
  logic            done;

  assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));
  assign busy    = (state != IDLE);

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_line;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) state_next = START;
      end
      START: begin
        // Centre of the start bit: still low means a real frame.
        if (cnt == CW'(HALF_BIT - 1)) state_next = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_en = 1'b1;
          if (idx == 3'd7) state_next = PARITY;
        end
      end
      PARITY: begin
        if (bit_end) begin
          par_en     = 1'b1;
          state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          done       = 1'b1;
          state_next = rx_s ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        // A held-low line (break) must return high before a new start edge counts.
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      sh         <= '0;
      par_bit    <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (state_next != state || bit_end) begin
        cnt <= '0;
      end else if (state inside {START, DATA, PARITY, STOP}) begin
        cnt <= cnt + CW'(1);
      end

      if (state == START) begin
        idx <= '0;
      end else if (shift_en) begin
        idx <= idx + 3'd1;
      end

      if (shift_en) sh <= {rx_s, sh[7:1]};
      if (par_en) par_bit <= rx_s;

      valid <= done;
      if (done) begin
        data       <= sh;
        parity_err <= (^sh) ^ par_bit;
        frame_err  <= ~rx_s;
      end
    end
  end

endmodule
